// File: rtl/lfsr_seg_sampler.sv
// lfsr_seg_sampler
// Samples a 4-bit LFSR state at a slow prescaled rate and shows it as a hex
// glyph on a 7-segment display. It also measures the LFSR sequence period in
// valid steps, so the selected feedback mode can be confirmed as maximal length.
module lfsr_seg_sampler #(
  parameter int unsigned PRESCALE = 1000000,  // clk cycles per display sample, 2..2^24
  parameter int unsigned CNT_W    = 5,        // period counter width
  parameter bit          SEG_INV  = 1'b0      // 1 = active-low segment outputs
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       lfsr_in,
  input  logic             lfsr_valid,
  input  logic             hold,
  input  logic             measure,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             sample_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_done,
  output logic             period_timeout
);

  // Prescaler sized to hold 0..PRESCALE-1; PRESCALE=2^24 still fits in 24 bits.
  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  // Counter saturation: a run that reaches all-ones steps without a repeat
  // is reported as a timeout.
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] CNT_PRE_SAT = CNT_SAT - CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Prescaler and sample tick
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  logic               presc_last;

  assign presc_last = (presc_q == PRESC_LAST);

  // Free-running prescaler; the tick is the registered wrap indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q  <= presc_last;
      presc_q <= presc_last ? '0 : presc_q + PRESC_W'(1);
    end
  end

  assign sample_tick = tick_q;

  // ---------------------------------------------------------------------------
  // Display register and decimal point
  // ---------------------------------------------------------------------------
  logic [3:0] disp_q;
  logic       dp_q;

  // Capture the LFSR value on the same edge that raises the tick, unless frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= 4'h0;
      dp_q   <= 1'b0;
    end else begin
      dp_q <= hold;
      if (presc_last && !hold) begin
        disp_q <= lfsr_in;
      end
    end
  end

  assign dp = dp_q;

  // ---------------------------------------------------------------------------
  // Hex to 7-segment decode, bit order {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  logic [6:0] glyph;

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    glyph = 7'h3F;
    case (disp_q)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h3F;
    endcase
  end

  assign seg = glyph ^ {7{SEG_INV}};

  // ---------------------------------------------------------------------------
  // Period measurement FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [3:0]         ref_q, ref_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d;
  logic               start;
  logic [CNT_W-1:0]   cnt_inc;

  assign start   = measure && lfsr_valid;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and measurement registers; reset abandons any run without a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ref_q     <= 4'h0;
      cnt_q     <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  // Next state: compare each valid step against the captured reference only.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new capture leaves the previous result visible until it completes.
        if (start) begin
          state_d = ST_COUNT;
          ref_d   = lfsr_in;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (lfsr_valid) begin
          if (lfsr_in == ref_q) begin
            period_d  = cnt_inc;
            timeout_d = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else if (cnt_q == CNT_PRE_SAT) begin
            period_d  = CNT_SAT;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign period         = period_q;
  assign period_done    = done_q;
  assign period_timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_seg_sampler.sv
// Self-checking bench for lfsr_seg_sampler (PRESCALE=4, CNT_W=5).
// Two instances share all inputs: one with active-high and one with
// active-low segments. Expected values come from a cycle-level reference
// model that works from the sampling and measurement rules directly.
module tb_lfsr_seg_sampler;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int          SAT      = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [3:0]       lfsr_in;
  logic             lfsr_valid;
  logic             hold;
  logic             measure;

  logic [6:0]       seg,            seg_n;
  logic             dp,             dp_n;
  logic             sample_tick,    sample_tick_n;
  logic [CNT_W-1:0] period,         period_n;
  logic             period_done,    period_done_n;
  logic             period_timeout, period_timeout_n;

  lfsr_seg_sampler #(.PRESCALE(PRESCALE), .CNT_W(CNT_W), .SEG_INV(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .lfsr_in(lfsr_in), .lfsr_valid(lfsr_valid),
    .hold(hold), .measure(measure), .seg(seg), .dp(dp),
    .sample_tick(sample_tick), .period(period), .period_done(period_done),
    .period_timeout(period_timeout)
  );

  lfsr_seg_sampler #(.PRESCALE(PRESCALE), .CNT_W(CNT_W), .SEG_INV(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .lfsr_in(lfsr_in), .lfsr_valid(lfsr_valid),
    .hold(hold), .measure(measure), .seg(seg_n), .dp(dp_n),
    .sample_tick(sample_tick_n), .period(period_n), .period_done(period_done_n),
    .period_timeout(period_timeout_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph table {g,f,e,d,c,b,a} for hex digits 0..F.
  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_edges;
  logic [3:0] m_disp;
  bit         m_tick, m_dp, m_done, m_timeout, m_active;
  int         m_period;
  logic [3:0] m_ref;
  logic [3:0] m_hist [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs the DUT just saw.
  task automatic model_edge();
    if (!rst_n) begin
      m_edges = 0; m_disp = 4'h0; m_tick = 0; m_dp = 0;
      m_period = 0; m_timeout = 0; m_done = 0; m_active = 0;
      m_hist.delete();
    end else begin
      m_edges++;
      m_tick = (m_edges % PRESCALE) == 0;
      if (m_tick && !hold) m_disp = lfsr_in;
      m_dp   = hold;
      m_done = 0;
      if (m_active) begin
        if (lfsr_valid) begin
          m_hist.push_back(lfsr_in);
          if (lfsr_in == m_ref) begin
            m_period = m_hist.size(); m_timeout = 0; m_done = 1; m_active = 0;
          end else if (m_hist.size() == SAT) begin
            m_period = SAT; m_timeout = 1; m_done = 1; m_active = 0;
          end
        end
      end else if (measure && lfsr_valid) begin
        m_active = 1; m_ref = lfsr_in; m_hist.delete();
      end
    end
  endtask

  // One clock: update model at the edge, compare both instances 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("tick",     32'(sample_tick),      32'(m_tick));
    check_eq("seg",      32'(seg),              32'(glyph_tab[m_disp]));
    check_eq("dp",       32'(dp),               32'(m_dp));
    check_eq("period",   32'(period),           32'(m_period));
    check_eq("done",     32'(period_done),      32'(m_done));
    check_eq("timeout",  32'(period_timeout),   32'(m_timeout));
    check_eq("seg_inv",  32'(seg_n),            32'(7'(~glyph_tab[m_disp])));
    check_eq("tick_i",   32'(sample_tick_n),    32'(m_tick));
    check_eq("dp_i",     32'(dp_n),             32'(m_dp));
    check_eq("period_i", 32'(period_n),         32'(m_period));
    check_eq("done_i",   32'(period_done_n),    32'(m_done));
    check_eq("to_i",     32'(period_timeout_n), 32'(m_timeout));
    if (m_done)
      $display("measurement complete: period=%0d timeout=%0d t=%0t", m_period, m_timeout, $time);
  endtask

  // Maximal-length 4-bit LFSR (x^4 + x^3 + 1).
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  logic [3:0] s;
  int         vcnt;
  int         guard;

  initial begin
    rst_n = 1'b0; lfsr_in = 4'h0; lfsr_valid = 1'b0; hold = 1'b0; measure = 1'b0;

    // Reset for two clocks, then watch the first tick appear 4 clocks later.
    step(); step();
    check_eq("rst_seg", 32'(seg), 32'h3F);
    check_eq("rst_period", 32'(period), 32'h0);
    rst_n = 1'b1;
    lfsr_in = 4'hA;
    for (int i = 0; i < 8; i++) step();
    check_eq("seg_A", 32'(seg), 32'h77);
    $display("phase: reset and sampling done");

    // Freeze the display; the prescaler keeps running.
    hold = 1'b1; lfsr_in = 4'h3;
    for (int i = 0; i < 8; i++) step();
    check_eq("seg_hold", 32'(seg), 32'h77);
    hold = 1'b0;

    // Decode sweep across all digits.
    for (int v = 0; v < 16; v++) begin
      lfsr_in = 4'(v);
      for (int i = 0; i < PRESCALE; i++) step();
    end
    $display("phase: decode sweep done");

    // Maximal sequence, valid every clock, single measure pulse.
    s = 4'h1; lfsr_valid = 1'b1; measure = 1'b1; lfsr_in = s;
    step();
    measure = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s = lfsr_next(s); lfsr_in = s; step();
    end
    check_eq("per15", 32'(period), 32'd15);
    check_eq("to15", 32'(period_timeout), 32'd0);

    // Same sequence with random valid gaps; garbage on lfsr_in while invalid.
    s = 4'h9; lfsr_valid = 1'b1; measure = 1'b1; lfsr_in = s;
    step();
    measure = 1'b0; vcnt = 0; guard = 0;
    while (vcnt < 17 && guard < 500) begin
      lfsr_valid = ($urandom_range(0, 2) != 0);
      if (lfsr_valid) begin s = lfsr_next(s); lfsr_in = s; vcnt++; end
      else lfsr_in = 4'($urandom_range(0, 15));
      step();
      guard++;
    end
    check_eq("gap_budget", 32'(vcnt >= 17), 32'd1);
    check_eq("per_gap", 32'(period), 32'd15);

    // Constant input repeats immediately.
    lfsr_valid = 1'b1; lfsr_in = 4'h5; measure = 1'b1;
    step();
    measure = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("per_const", 32'(period), 32'd1);

    // Reference 0, then values 1..15 cycling: never repeats, saturates.
    lfsr_in = 4'h0; measure = 1'b1;
    step();
    measure = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      lfsr_in = 4'(1 + ((k - 1) % 15)); step();
    end
    check_eq("per_sat", 32'(period), 32'(SAT));
    check_eq("to_sat", 32'(period_timeout), 32'd1);
    $display("phase: gaps, constant and saturation done");

    // Reset after 7 counted steps, then a clean measurement.
    s = 4'h1; lfsr_in = s; measure = 1'b1;
    step();
    measure = 1'b0;
    for (int i = 0; i < 7; i++) begin s = lfsr_next(s); lfsr_in = s; step(); end
    rst_n = 1'b0;
    step();
    check_eq("rst_mid_period", 32'(period), 32'd0);
    check_eq("rst_mid_done", 32'(period_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin s = lfsr_next(s); lfsr_in = s; step(); end
    measure = 1'b1; step(); measure = 1'b0;
    for (int i = 0; i < 18; i++) begin s = lfsr_next(s); lfsr_in = s; step(); end
    check_eq("per_after_rst", 32'(period), 32'd15);

    // Back-to-back measurements with measure held high and random gaps.
    measure = 1'b1;
    for (int i = 0; i < 80; i++) begin
      lfsr_valid = ($urandom_range(0, 3) != 0);
      if (lfsr_valid) begin s = lfsr_next(s); lfsr_in = s; end
      step();
    end
    measure = 1'b0;

    // Fully random traffic.
    for (int i = 0; i < 300; i++) begin
      lfsr_valid = ($urandom_range(0, 3) != 0);
      hold       = ($urandom_range(0, 3) == 0);
      measure    = ($urandom_range(0, 7) == 0);
      if (lfsr_valid) begin s = lfsr_next(s); lfsr_in = s; end
      else lfsr_in = 4'($urandom_range(0, 15));
      step();
    end
    $display("phase: random traffic done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
